// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit ripple-carry stage.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Purely combinational 4-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder_4bit
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_c_in,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_c_out
);

    logic [NIBBLE_W:0] w_carry;

    assign w_carry[0] = i_c_in;

    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
        assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
        assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_c_out = w_carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit adder,
// carry registered between nibbles, valid/ready handshakes on both sides.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_carry;
    logic                r_c_out;
    logic [IDX_W-1:0]    r_idx;

    logic [NIBBLE_W-1:0] w_a_nib [NIB];
    logic [NIBBLE_W-1:0] w_b_nib [NIB];
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_carry;
    logic                w_accept;
    logic                w_step;
    logic                w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_step   = (r_state == ADD);
    assign w_last   = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = ADD;
            ADD:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, carry chain and step index; idx parks on the last nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_c_out <= 1'b0;
            r_idx   <= '0;
        end else if (w_step) begin
            r_carry <= w_nib_carry;
            if (w_last) begin
                r_c_out <= w_nib_carry;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        logic [NIBBLE_W-1:0] r_sum_nib;

        assign w_a_nib[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
        assign w_b_nib[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];

        always_ff @(posedge clk) begin
            if (rst || w_accept) begin
                r_sum_nib <= '0;
            end else if (w_step && (r_idx == IDX_W'(gi))) begin
                r_sum_nib <= w_nib_sum;
            end
        end

        assign sum[gi*NIBBLE_W +: NIBBLE_W] = r_sum_nib;
    end

    ripple_carry_adder_4bit u_rca (
        .i_a     (w_a_nib[r_idx]),
        .i_b     (w_b_nib[r_idx]),
        .i_c_in  (r_carry),
        .o_sum   (w_nib_sum),
        .o_c_out (w_nib_carry)
    );

    // in_ready is masked while rst is held so nothing is offered during reset.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign c_out     = r_c_out;

endmodule
